// File: rtl/id_ex_operand_reg_if.sv
// -----------------------------------------------------------------------------
// id_ex_operand_reg_if
//   Bundles every signal between the decode stage, the register file / write-back
//   path and the EX stage around the ID/EX operand register.
//
//   Signal groups:
//     ID side   : IF_Valid, IF_Rs, IF_Rt, IF_Rd, IF_Imm, IF_ImmZext, IF_Ctrl
//     Reg file  : r1_dout, r2_dout
//     Write-back: MW_RegWrite, MW_WBAddr, MW_WBData
//     Control   : flush, ex_hold, stall_o
//     EX side   : IE_Valid, IE_A, IE_B, IE_Imm, IE_Rs, IE_Rt, IE_Rd, IE_Ctrl
//
//   Modports:
//     master : the surrounding pipeline (drives ID/WB/control, observes IE_*).
//     slave  : the ID/EX register itself.
// -----------------------------------------------------------------------------
interface id_ex_operand_reg_if #(
  parameter int CTRL_W = 12
);
  // ID stage fields
  logic              IF_Valid;
  logic [4:0]        IF_Rs;
  logic [4:0]        IF_Rt;
  logic [4:0]        IF_Rd;
  logic [15:0]       IF_Imm;
  logic              IF_ImmZext;
  logic [CTRL_W-1:0] IF_Ctrl;

  // Register file read data
  logic [31:0]       r1_dout;
  logic [31:0]       r2_dout;

  // Write-back port (same net that writes the register file)
  logic              MW_RegWrite;
  logic [4:0]        MW_WBAddr;
  logic [31:0]       MW_WBData;

  // Pipeline control
  logic              flush;
  logic              ex_hold;
  logic              stall_o;

  // EX stage fields
  logic              IE_Valid;
  logic [31:0]       IE_A;
  logic [31:0]       IE_B;
  logic [31:0]       IE_Imm;
  logic [4:0]        IE_Rs;
  logic [4:0]        IE_Rt;
  logic [4:0]        IE_Rd;
  logic [CTRL_W-1:0] IE_Ctrl;

  modport master (
    output IF_Valid, IF_Rs, IF_Rt, IF_Rd, IF_Imm, IF_ImmZext, IF_Ctrl,
    output r1_dout, r2_dout,
    output MW_RegWrite, MW_WBAddr, MW_WBData,
    output flush, ex_hold,
    input  stall_o,
    input  IE_Valid, IE_A, IE_B, IE_Imm, IE_Rs, IE_Rt, IE_Rd, IE_Ctrl
  );

  modport slave (
    input  IF_Valid, IF_Rs, IF_Rt, IF_Rd, IF_Imm, IF_ImmZext, IF_Ctrl,
    input  r1_dout, r2_dout,
    input  MW_RegWrite, MW_WBAddr, MW_WBData,
    input  flush, ex_hold,
    output stall_o,
    output IE_Valid, IE_A, IE_B, IE_Imm, IE_Rs, IE_Rt, IE_Rd, IE_Ctrl
  );
endinterface

// File: rtl/id_ex_operand_reg.sv
// -----------------------------------------------------------------------------
// id_ex_operand_reg
//   ID/EX pipeline register placed directly after the register file.
//   - Captures the decoded fields and both register read values.
//   - Forwards a same-cycle write-back into the captured operands, because the
//     register file returns the old value when read and written in one cycle.
//   - Detects a load followed by a dependent instruction, inserts one bubble
//     and raises stall_o so the ID instruction is presented again.
//   - A flush squashes the ID instruction; ex_hold freezes the register.
//
//   Ports:
//     clk       : rising-edge clock
//     rst_n     : asynchronous active-low reset, clears all IE_* outputs
//     bus       : id_ex_operand_reg_if.slave (ID, reg file, WB, control, EX)
//     stall_cnt : (ID_PERF_CNT_EN only) cycles lost to load-use stalls
//     bubble_cnt: (ID_PERF_CNT_EN only) cycles that loaded a bubble
//
//   Optional feature macro: ID_PERF_CNT_EN adds the two performance counters.
//   With the macro undefined neither port nor any counter logic exists.
// -----------------------------------------------------------------------------
module id_ex_operand_reg #(
  parameter int CTRL_W    = 12,
  parameter int MEMRD_BIT = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  id_ex_operand_reg_if.slave  bus
`ifdef ID_PERF_CNT_EN
  ,
  output logic [31:0]         stall_cnt,
  output logic [31:0]         bubble_cnt
`endif
);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic              ie_valid_reg;
  logic [31:0]       ie_a_reg;
  logic [31:0]       ie_b_reg;
  logic [31:0]       ie_imm_reg;
  logic [4:0]        ie_rs_reg;
  logic [4:0]        ie_rt_reg;
  logic [4:0]        ie_rd_reg;
  logic [CTRL_W-1:0] ie_ctrl_reg;

  // ---------------------------------------------------------------------------
  // Combinational helpers
  // ---------------------------------------------------------------------------
  logic              wb_active;
  logic              bypass_a;
  logic              bypass_b;
  logic [31:0]       oper_a;
  logic [31:0]       oper_b;
  logic [31:0]       imm_ext;
  logic              ie_is_load;
  logic              rt_hit_rs;
  logic              rt_hit_rt;
  logic              load_use;
  logic              take_hold;
  logic              take_bubble;
  logic [CTRL_W-1:0] ctrl_next;

  // Register 0 is hard-wired to zero, so a write-back to it is never forwarded.
  assign wb_active = bus.MW_RegWrite && (bus.MW_WBAddr != 5'd0);
  assign bypass_a  = wb_active && (bus.MW_WBAddr == bus.IF_Rs);
  assign bypass_b  = wb_active && (bus.MW_WBAddr == bus.IF_Rt);

  assign oper_a = bypass_a ? bus.MW_WBData : bus.r1_dout;
  assign oper_b = bypass_b ? bus.MW_WBData : bus.r2_dout;

  assign imm_ext = bus.IF_ImmZext ? {16'h0000, bus.IF_Imm}
                                  : {{16{bus.IF_Imm[15]}}, bus.IF_Imm};

  // Load-use: the instruction in EX is a load whose destination (Rt) is read
  // by the instruction currently in ID. A load into r0 never creates a hazard.
  assign ie_is_load = ie_valid_reg && ie_ctrl_reg[MEMRD_BIT];
  assign rt_hit_rs  = (ie_rt_reg == bus.IF_Rs);
  assign rt_hit_rt  = (ie_rt_reg == bus.IF_Rt);
  assign load_use   = ie_is_load && (ie_rt_reg != 5'd0) && bus.IF_Valid &&
                      (rt_hit_rs || rt_hit_rt);

  // ex_hold dominates everything, including flush; the flush source keeps
  // flush asserted until the hold is released, so it is not lost here.
  assign take_hold   = bus.ex_hold;
  assign take_bubble = !bus.ex_hold && (bus.flush || load_use);

  // A flushed load-use needs no stall: the dependent instruction is squashed.
  assign bus.stall_o = bus.ex_hold | (load_use & ~bus.flush);

  // An empty ID slot must not carry live control into EX.
  assign ctrl_next = bus.IF_Valid ? bus.IF_Ctrl : '0;

  // ---------------------------------------------------------------------------
  // ID/EX register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ie_valid_reg <= 1'b0;
      ie_a_reg     <= '0;
      ie_b_reg     <= '0;
      ie_imm_reg   <= '0;
      ie_rs_reg    <= '0;
      ie_rt_reg    <= '0;
      ie_rd_reg    <= '0;
      ie_ctrl_reg  <= '0;
    end else if (take_hold) begin
      ie_valid_reg <= ie_valid_reg;
      ie_a_reg     <= ie_a_reg;
      ie_b_reg     <= ie_b_reg;
      ie_imm_reg   <= ie_imm_reg;
      ie_rs_reg    <= ie_rs_reg;
      ie_rt_reg    <= ie_rt_reg;
      ie_rd_reg    <= ie_rd_reg;
      ie_ctrl_reg  <= ie_ctrl_reg;
    end else if (take_bubble) begin
      // Bubble: everything cleared so a stale register number can never
      // match a later hazard or forwarding comparison downstream.
      ie_valid_reg <= 1'b0;
      ie_a_reg     <= '0;
      ie_b_reg     <= '0;
      ie_imm_reg   <= '0;
      ie_rs_reg    <= '0;
      ie_rt_reg    <= '0;
      ie_rd_reg    <= '0;
      ie_ctrl_reg  <= '0;
    end else begin
      ie_valid_reg <= bus.IF_Valid;
      ie_a_reg     <= oper_a;
      ie_b_reg     <= oper_b;
      ie_imm_reg   <= imm_ext;
      ie_rs_reg    <= bus.IF_Rs;
      ie_rt_reg    <= bus.IF_Rt;
      ie_rd_reg    <= bus.IF_Rd;
      ie_ctrl_reg  <= ctrl_next;
    end
  end

  assign bus.IE_Valid = ie_valid_reg;
  assign bus.IE_A     = ie_a_reg;
  assign bus.IE_B     = ie_b_reg;
  assign bus.IE_Imm   = ie_imm_reg;
  assign bus.IE_Rs    = ie_rs_reg;
  assign bus.IE_Rt    = ie_rt_reg;
  assign bus.IE_Rd    = ie_rd_reg;
  assign bus.IE_Ctrl  = ie_ctrl_reg;

`ifdef ID_PERF_CNT_EN
  // ---------------------------------------------------------------------------
  // Performance counters (free-running, wrap at 2^32)
  // ---------------------------------------------------------------------------
  logic [31:0] stall_cnt_reg;
  logic [31:0] bubble_cnt_reg;
  logic        lu_stall_event;

  // Only cycles lost purely to the load-use interlock count as stalls.
  assign lu_stall_event = load_use & ~bus.flush & ~bus.ex_hold;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_reg  <= '0;
      bubble_cnt_reg <= '0;
    end else begin
      if (lu_stall_event) begin
        stall_cnt_reg <= stall_cnt_reg + 32'd1;
      end
      if (take_bubble) begin
        bubble_cnt_reg <= bubble_cnt_reg + 32'd1;
      end
    end
  end

  assign stall_cnt  = stall_cnt_reg;
  assign bubble_cnt = bubble_cnt_reg;
`endif

endmodule

// File: tb/tb_id_ex_operand_reg.sv
// -----------------------------------------------------------------------------
// tb_id_ex_operand_reg
//   Directed self-checking bench for id_ex_operand_reg. Each scenario task
//   drives inputs shortly after a rising edge, checks combinational stall_o
//   before the next edge and registered IE_* outputs 1 ns after it.
// -----------------------------------------------------------------------------
module tb_id_ex_operand_reg;

  logic clk;
  logic rst_n;
  int   passed;
  int   total;

  id_ex_operand_reg_if #(.CTRL_W(12)) bus ();

`ifdef ID_PERF_CNT_EN
  logic [31:0] stall_cnt;
  logic [31:0] bubble_cnt;
`endif

  id_ex_operand_reg #(.CTRL_W(12), .MEMRD_BIT(0)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus.slave)
`ifdef ID_PERF_CNT_EN
    ,
    .stall_cnt  (stall_cnt),
    .bubble_cnt (bubble_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Stimulus helpers (drive only)
  // ---------------------------------------------------------------------------
  task automatic drive(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] rd, input logic [15:0] imm, input logic zx,
                       input logic [11:0] ctrl, input logic [31:0] r1,
                       input logic [31:0] r2);
    bus.IF_Valid   = v;
    bus.IF_Rs      = rs;
    bus.IF_Rt      = rt;
    bus.IF_Rd      = rd;
    bus.IF_Imm     = imm;
    bus.IF_ImmZext = zx;
    bus.IF_Ctrl    = ctrl;
    bus.r1_dout    = r1;
    bus.r2_dout    = r2;
  endtask

  task automatic wb(input logic we, input logic [4:0] addr, input logic [31:0] data);
    bus.MW_RegWrite = we;
    bus.MW_WBAddr   = addr;
    bus.MW_WBData   = data;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    drive(1'b1, 5'd1, 5'd2, 5'd3, 16'h1234, 1'b0, 12'h0F0, 32'hAAAA_0001, 32'hBBBB_0002);
    wb(1'b0, 5'd0, 32'h0);
    step();
    total++; if (bus.IE_Valid !== 1'b1) $display("FAIL reset_pre_valid: got %b expected %b", bus.IE_Valid, 1'b1); else passed++;
    #2 rst_n = 1'b0;
    #1;
    total++; if (bus.IE_Valid !== 1'b0) $display("FAIL reset_valid: got %b expected %b", bus.IE_Valid, 1'b0); else passed++;
    total++; if (bus.IE_A !== 32'h0) $display("FAIL reset_a: got %h expected %h", bus.IE_A, 32'h0); else passed++;
    total++; if (bus.IE_B !== 32'h0) $display("FAIL reset_b: got %h expected %h", bus.IE_B, 32'h0); else passed++;
    total++; if (bus.IE_Imm !== 32'h0) $display("FAIL reset_imm: got %h expected %h", bus.IE_Imm, 32'h0); else passed++;
    total++; if (bus.IE_Ctrl !== 12'h0) $display("FAIL reset_ctrl: got %h expected %h", bus.IE_Ctrl, 12'h0); else passed++;
    total++; if ({bus.IE_Rs, bus.IE_Rt, bus.IE_Rd} !== 15'h0) $display("FAIL reset_regs: got %h expected %h", {bus.IE_Rs, bus.IE_Rt, bus.IE_Rd}, 15'h0); else passed++;
    total++; if (bus.stall_o !== 1'b0) $display("FAIL reset_stall: got %b expected %b", bus.stall_o, 1'b0); else passed++;
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_bypass();
    // Forward to A, B from register file
    drive(1'b1, 5'd5, 5'd6, 5'd7, 16'h0, 1'b0, 12'h002, 32'h0000_0011, 32'h0000_0022);
    wb(1'b1, 5'd5, 32'h0000_CAFE);
    step();
    total++; if (bus.IE_A !== 32'h0000_CAFE) $display("FAIL bypass_a: got %h expected %h", bus.IE_A, 32'h0000_CAFE); else passed++;
    total++; if (bus.IE_B !== 32'h0000_0022) $display("FAIL bypass_b_nohit: got %h expected %h", bus.IE_B, 32'h0000_0022); else passed++;
    // WB address 0: no forwarding
    wb(1'b1, 5'd0, 32'h0000_CAFE);
    step();
    total++; if (bus.IE_A !== 32'h0000_0011) $display("FAIL bypass_addr0: got %h expected %h", bus.IE_A, 32'h0000_0011); else passed++;
    // Reading r0 while WB targets r0: stays zero
    drive(1'b1, 5'd0, 5'd0, 5'd7, 16'h0, 1'b0, 12'h002, 32'h0, 32'h0);
    step();
    total++; if (bus.IE_A !== 32'h0) $display("FAIL bypass_r0: got %h expected %h", bus.IE_A, 32'h0); else passed++;
    // Forward to B; RegWrite low disables A forwarding
    drive(1'b1, 5'd9, 5'd10, 5'd7, 16'h0, 1'b0, 12'h002, 32'h0000_0099, 32'h0000_00AA);
    wb(1'b1, 5'd10, 32'h1357_2468);
    step();
    total++; if (bus.IE_B !== 32'h1357_2468) $display("FAIL bypass_b: got %h expected %h", bus.IE_B, 32'h1357_2468); else passed++;
    wb(1'b0, 5'd9, 32'hFFFF_FFFF);
    step();
    total++; if (bus.IE_A !== 32'h0000_0099) $display("FAIL bypass_we0: got %h expected %h", bus.IE_A, 32'h0000_0099); else passed++;
    wb(1'b0, 5'd0, 32'h0);
  endtask

  task automatic test_imm();
    drive(1'b1, 5'd1, 5'd2, 5'd3, 16'h8001, 1'b0, 12'h004, 32'h0, 32'h0);
    step();
    total++; if (bus.IE_Imm !== 32'hFFFF_8001) $display("FAIL imm_sext: got %h expected %h", bus.IE_Imm, 32'hFFFF_8001); else passed++;
    drive(1'b1, 5'd1, 5'd2, 5'd3, 16'h8001, 1'b1, 12'h004, 32'h0, 32'h0);
    step();
    total++; if (bus.IE_Imm !== 32'h0000_8001) $display("FAIL imm_zext: got %h expected %h", bus.IE_Imm, 32'h0000_8001); else passed++;
    drive(1'b1, 5'd1, 5'd2, 5'd3, 16'h7FFF, 1'b0, 12'h004, 32'h0, 32'h0);
    step();
    total++; if (bus.IE_Imm !== 32'h0000_7FFF) $display("FAIL imm_pos: got %h expected %h", bus.IE_Imm, 32'h0000_7FFF); else passed++;
  endtask

  task automatic test_load_use();
    // lw r8
    drive(1'b1, 5'd1, 5'd8, 5'd0, 16'h0004, 1'b0, 12'h001, 32'h0, 32'h0);
    step();
    total++; if (bus.IE_Rt !== 5'd8) $display("FAIL lu_load_rt: got %0d expected %0d", bus.IE_Rt, 5'd8); else passed++;
    // consumer of r8
    drive(1'b1, 5'd3, 5'd8, 5'd9, 16'h0004, 1'b0, 12'h010, 32'h0000_0033, 32'h0000_0088);
    #1;
    total++; if (bus.stall_o !== 1'b1) $display("FAIL lu_stall: got %b expected %b", bus.stall_o, 1'b1); else passed++;
    step();
    total++; if (bus.IE_Valid !== 1'b0) $display("FAIL lu_bubble_valid: got %b expected %b", bus.IE_Valid, 1'b0); else passed++;
    total++; if (bus.IE_Ctrl !== 12'h0) $display("FAIL lu_bubble_ctrl: got %h expected %h", bus.IE_Ctrl, 12'h0); else passed++;
    total++; if (bus.stall_o !== 1'b0) $display("FAIL lu_stall_clear: got %b expected %b", bus.stall_o, 1'b0); else passed++;
    // load data arrives on write-back during the re-presented cycle
    wb(1'b1, 5'd8, 32'h0000_BEEF);
    step();
    total++; if (bus.IE_Valid !== 1'b1) $display("FAIL lu_replay_valid: got %b expected %b", bus.IE_Valid, 1'b1); else passed++;
    total++; if (bus.IE_Ctrl !== 12'h010) $display("FAIL lu_replay_ctrl: got %h expected %h", bus.IE_Ctrl, 12'h010); else passed++;
    total++; if (bus.IE_B !== 32'h0000_BEEF) $display("FAIL lu_replay_bypass: got %h expected %h", bus.IE_B, 32'h0000_BEEF); else passed++;
    total++; if (bus.IE_Rd !== 5'd9) $display("FAIL lu_replay_rd: got %0d expected %0d", bus.IE_Rd, 5'd9); else passed++;
    wb(1'b0, 5'd0, 32'h0);
    // load into r0 never stalls
    drive(1'b1, 5'd1, 5'd0, 5'd0, 16'h0, 1'b0, 12'h001, 32'h0, 32'h0);
    step();
    drive(1'b1, 5'd0, 5'd0, 5'd4, 16'h0, 1'b0, 12'h010, 32'h0, 32'h0);
    #1;
    total++; if (bus.stall_o !== 1'b0) $display("FAIL lu_r0_nostall: got %b expected %b", bus.stall_o, 1'b0); else passed++;
    step();
  endtask

  task automatic test_flush_lu();
    drive(1'b1, 5'd1, 5'd8, 5'd0, 16'h0, 1'b0, 12'h001, 32'h0, 32'h0);
    step();
    drive(1'b1, 5'd8, 5'd2, 5'd4, 16'h0, 1'b0, 12'h010, 32'h0000_0055, 32'h0000_0066);
    bus.flush = 1'b1;
    #1;
    total++; if (bus.stall_o !== 1'b0) $display("FAIL flush_lu_stall: got %b expected %b", bus.stall_o, 1'b0); else passed++;
    step();
    total++; if (bus.IE_Valid !== 1'b0) $display("FAIL flush_lu_valid: got %b expected %b", bus.IE_Valid, 1'b0); else passed++;
    total++; if (bus.IE_A !== 32'h0) $display("FAIL flush_lu_a: got %h expected %h", bus.IE_A, 32'h0); else passed++;
    total++; if (bus.IE_Ctrl !== 12'h0) $display("FAIL flush_lu_ctrl: got %h expected %h", bus.IE_Ctrl, 12'h0); else passed++;
    bus.flush = 1'b0;
  endtask

  task automatic test_hold();
    drive(1'b1, 5'd4, 5'd5, 5'd6, 16'h0010, 1'b0, 12'h0A0, 32'h0000_1234, 32'h0000_5678);
    step();
    total++; if (bus.IE_A !== 32'h0000_1234) $display("FAIL hold_load: got %h expected %h", bus.IE_A, 32'h0000_1234); else passed++;
    drive(1'b1, 5'd7, 5'd7, 5'd7, 16'hFFFF, 1'b0, 12'hFFE, 32'hDEAD_0000, 32'hBEEF_0000);
    bus.ex_hold = 1'b1;
    bus.flush   = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      total++; if (bus.stall_o !== 1'b1) $display("FAIL hold_stall_%0d: got %b expected %b", i, bus.stall_o, 1'b1); else passed++;
      step();
      bus.flush = 1'b0;
      total++; if ({bus.IE_Valid, bus.IE_A, bus.IE_B, bus.IE_Ctrl, bus.IE_Rd} !== {1'b1, 32'h0000_1234, 32'h0000_5678, 12'h0A0, 5'd6})
        $display("FAIL hold_keep_%0d: got %h expected %h", i, {bus.IE_Valid, bus.IE_A, bus.IE_B, bus.IE_Ctrl, bus.IE_Rd},
                 {1'b1, 32'h0000_1234, 32'h0000_5678, 12'h0A0, 5'd6});
      else passed++;
    end
    bus.ex_hold = 1'b0;
    #1;
    total++; if (bus.stall_o !== 1'b0) $display("FAIL hold_release_stall: got %b expected %b", bus.stall_o, 1'b0); else passed++;
    step();
    total++; if (bus.IE_A !== 32'hDEAD_0000) $display("FAIL hold_release_load: got %h expected %h", bus.IE_A, 32'hDEAD_0000); else passed++;
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 5'(i + 1), 5'(i + 11), 5'(i + 21), 16'(i), 1'b0, 12'h020,
            32'h0000_0100 + 32'(i), 32'h0000_0200 + 32'(i));
      step();
      total++; if ({bus.IE_A, bus.IE_Rd} !== {32'h0000_0100 + 32'(i), 5'(i + 21)})
        $display("FAIL b2b_%0d: got %h expected %h", i, {bus.IE_A, bus.IE_Rd}, {32'h0000_0100 + 32'(i), 5'(i + 21)});
      else passed++;
    end
    drive(1'b0, 5'd1, 5'd2, 5'd3, 16'h0, 1'b0, 12'hFFF, 32'h0, 32'h0);
    step();
    total++; if (bus.IE_Valid !== 1'b0) $display("FAIL invalid_valid: got %b expected %b", bus.IE_Valid, 1'b0); else passed++;
    total++; if (bus.IE_Ctrl !== 12'h0) $display("FAIL invalid_ctrl: got %h expected %h", bus.IE_Ctrl, 12'h0); else passed++;
  endtask

  task automatic test_reset_mid_stall();
    drive(1'b1, 5'd1, 5'd8, 5'd0, 16'h0, 1'b0, 12'h001, 32'h0, 32'h0);
    step();
    drive(1'b1, 5'd8, 5'd3, 5'd4, 16'h0, 1'b0, 12'h010, 32'h0, 32'h0);
    #1;
    total++; if (bus.stall_o !== 1'b1) $display("FAIL rst_stall_pre: got %b expected %b", bus.stall_o, 1'b1); else passed++;
    rst_n = 1'b0;
    #1;
    total++; if (bus.stall_o !== 1'b0) $display("FAIL rst_stall_post: got %b expected %b", bus.stall_o, 1'b0); else passed++;
    total++; if (bus.IE_Rt !== 5'd0) $display("FAIL rst_stall_rt: got %0d expected %0d", bus.IE_Rt, 5'd0); else passed++;
    rst_n = 1'b1;
    drive(1'b0, 5'd0, 5'd0, 5'd0, 16'h0, 1'b0, 12'h0, 32'h0, 32'h0);
    step();
  endtask

  // ---------------------------------------------------------------------------
  // Sequencer
  // ---------------------------------------------------------------------------
  initial begin
    passed      = 0;
    total       = 0;
    rst_n       = 1'b0;
    bus.flush   = 1'b0;
    bus.ex_hold = 1'b0;
    drive(1'b0, 5'd0, 5'd0, 5'd0, 16'h0, 1'b0, 12'h0, 32'h0, 32'h0);
    wb(1'b0, 5'd0, 32'h0);
    step();
    step();
    rst_n = 1'b1;
    step();

    test_reset();
    test_bypass();
    test_imm();
    test_load_use();
    test_flush_lu();
    test_hold();
    test_back_to_back();
    test_reset_mid_stall();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
